// File: rtl/indicator_decoder.sv
// Multiplexed 7-segment display sniffer: rebuilds a 4-digit hex value from digit strobes.
// Optional error detection is compiled in with macro INDICATOR_DECODER_ERR_CHECK_EN.
module indicator_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int STABLE_WIDTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  one_segment,
  input  logic [3:0]  dig_n,
  output logic [15:0] number,
  output logic        number_valid,
  output logic        frame_error,
  output logic [7:0]  error_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [STABLE_WIDTH-1:0] TARGET = STABLE_WIDTH'(STABLE_CYCLES);

  state_t                  state, state_next;
  logic [STABLE_WIDTH-1:0] cnt, cnt_next;
  logic [6:0]              seg_q, lat_seg;
  logic [3:0]              dig_q;
  logic [1:0]              idx, lat_idx;
  logic [2:0]              low_count;
  logic                    single, same, latch, sample;
  logic                    legal, full, valid_pend;
  logic [3:0]              nib, mask, mask_new;
  logic [15:0]             shadow, merged;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = {1'b1, 4'h0};
      7'h06: decode = {1'b1, 4'h1};
      7'h5B: decode = {1'b1, 4'h2};
      7'h4F: decode = {1'b1, 4'h3};
      7'h66: decode = {1'b1, 4'h4};
      7'h6D: decode = {1'b1, 4'h5};
      7'h7D: decode = {1'b1, 4'h6};
      7'h07: decode = {1'b1, 4'h7};
      7'h7F: decode = {1'b1, 4'h8};
      7'h6F: decode = {1'b1, 4'h9};
      7'h77: decode = {1'b1, 4'hA};
      7'h7C: decode = {1'b1, 4'hB};
      7'h39: decode = {1'b1, 4'hC};
      7'h5E: decode = {1'b1, 4'hD};
      7'h79: decode = {1'b1, 4'hE};
      7'h71: decode = {1'b1, 4'hF};
      default: decode = 5'b0_0000;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q <= '0;
      dig_q <= 4'hF;
    end else begin
      seg_q <= one_segment;
      dig_q <= dig_n;
    end
  end

  always_comb begin
    low_count = {2'b00, ~dig_q[0]} + {2'b00, ~dig_q[1]} + {2'b00, ~dig_q[2]} + {2'b00, ~dig_q[3]};
    single    = (low_count == 3'd1);
    idx       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!dig_q[i]) idx = 2'(i);
    end
    same = (idx == lat_idx) && (seg_q == lat_seg);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Any path that lands in SETTLE with the target count samples at once and parks in HOLD.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch      = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (single) begin
          state_next = SETTLE;
          cnt_next   = 1;
          latch      = 1'b1;
        end
      end
      SETTLE: begin
        if (!single) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (same) begin
          if (cnt < TARGET) cnt_next = cnt + 1'b1;
        end else begin
          cnt_next = 1;
          latch    = 1'b1;
        end
      end
      HOLD: begin
        if (!single) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (!same) begin
          state_next = SETTLE;
          cnt_next   = 1;
          latch      = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (state_next == SETTLE && cnt_next == TARGET) begin
      sample     = 1'b1;
      state_next = HOLD;
    end
  end

  always_comb begin
    {legal, nib}           = decode(seg_q);
    mask_new               = mask | (4'b0001 << idx);
    full                   = legal && (mask_new == 4'hF);
    merged                 = shadow;
    merged[{idx, 2'b00} +: 4] = nib;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      lat_idx      <= '0;
      lat_seg      <= '0;
      shadow       <= '0;
      mask         <= '0;
      number       <= '0;
      valid_pend   <= 1'b0;
      number_valid <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      number_valid <= valid_pend;
      valid_pend   <= 1'b0;
      if (latch) begin
        lat_idx <= idx;
        lat_seg <= seg_q;
      end
      if (sample && legal) begin
        shadow <= merged;
        if (full) begin
          number     <= merged;
          mask       <= '0;
          valid_pend <= 1'b1;
        end else begin
          mask <= mask_new;
        end
      end
    end
  end

`ifdef INDICATOR_DECODER_ERR_CHECK_EN
  logic multi, prev_multi, err_ev;

  always_comb begin
    multi  = (low_count >= 3'd2);
    err_ev = (sample && !legal) || (multi && !prev_multi);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_multi  <= 1'b0;
      frame_error <= 1'b0;
      error_count <= '0;
    end else begin
      prev_multi  <= multi;
      frame_error <= err_ev;
      if (err_ev && error_count != 8'hFF) error_count <= error_count + 8'd1;
    end
  end
`else
  assign frame_error = 1'b0;
  assign error_count = 8'h00;
`endif

endmodule
